zsdram_cmd_sequencer: RTL
=========================

Name: zsdram_cmd_sequencer

Overview:
- Initiator-side sequencer that drives the one-hot call/done interface of the SDRAM function (PHY command) module.
- Issues the power-up initial call, then schedules periodic refresh, and arbitrates user write and read requests into single-word calls.
- Sits between the photon-counter data path (user side) and the SDRAM function module (function side).

Parameters:
- REFRESH_INTERVAL, 16'd1037: clk cycles between refresh requests (7.8 us at 133 MHz).
- DONE_TIMEOUT, 16'd20000: maximum cycles a call may stay outstanding before it is flagged as an error.

Ports:
- clk  in  1  system clock, 133 MHz.
- rst  in  1  asynchronous, active-high reset.
- wr_req  in  1  write request; held high until wr_ack.
- wr_addr  in  24  bank(2)+row(13)+column(9).
- wr_data  in  16  write word.
- wr_ack  out  1  one-cycle pulse: write completed.
- rd_req  in  1  read request; held high until rd_ack.
- rd_addr  in  24  read address.
- rd_ack  out  1  one-cycle pulse: read completed.
- rd_data  out  16  read word; valid when rd_ack is high and held after.
- init_done  out  1  high once initialisation has completed.
- ref_overrun  out  1  sticky: a refresh tick occurred while a refresh was already pending.
- timeout_err  out  1  sticky: DONE_TIMEOUT expired.
- oCall  out  4  one-hot call: [3] write, [2] read, [1] refresh, [0] initial.
- iDone  in  1  one-cycle done pulse from the function module.
- oAddr  out  24  call address.
- oData  out  16  write data to the function module.
- iData  in  16  read data from the function module; valid when iDone is high.

Behaviour:
- Reset values: oCall=0, oAddr=0, oData=0, wr_ack=0, rd_ack=0, rd_data=0, init_done=0, ref_overrun=0, timeout_err=0; refresh counter=0; state=INIT; rr_last=READ.
- States: INIT, IDLE, WRITE, READ, REFRESH, GAP.
- INIT:
  - oCall=0001 from the first cycle after rst is released.
  - On iDone: oCall=0 on the next edge; init_done=1 on the same edge; go to GAP.
- iDone is ignored whenever oCall==0. The function module asserts done high out of reset, so this pulse must not be acted on.
- Refresh counter:
  - Runs only while init_done=1, including during calls.
  - At REFRESH_INTERVAL-1 it wraps to 0 and sets ref_pending.
  - If ref_pending is already set at a wrap, ref_overrun is set to 1.
- IDLE arbitration, evaluated every cycle:
  - Priority 1: ref_pending.
  - Priority 2: user requests.
  - If both wr_req and rd_req are high, the type not served last (rr_last) wins.
  - If only one request is high, it wins.
- Dispatch latency: from IDLE with a winning request, the call is driven on the next edge (1 cycle).
  - WRITE: oCall=1000, oAddr=wr_addr, oData=wr_data. Address and data are captured at dispatch and held stable until done.
  - READ: oCall=0100, oAddr=rd_addr.
  - REFRESH: oCall=0010; ref_pending is cleared at dispatch.
- A wrap coinciding with refresh dispatch sets ref_pending again; ref_overrun is not set.
- Completion on iDone:
  - oCall=0 on the next edge.
  - WRITE: wr_ack=1 for one cycle; rr_last=WRITE.
  - READ: rd_data<=iData; rd_ack=1 for one cycle; rr_last=READ.
  - REFRESH: no user-side pulse.
  - Then go to GAP.
- GAP: one mandatory cycle with oCall=0, so the function module returns to step 0 between calls; then IDLE.
- oCall is exactly one-hot or zero at all times; it never changes while a call is outstanding.
- Timeout: a per-call counter clears at dispatch. If it reaches DONE_TIMEOUT-1 without iDone:
  - timeout_err=1.
  - oCall=0; go to GAP.
  - No ack is issued; the user request remains pending and is retried.
  - In INIT, oCall=0001 is re-issued after GAP.
- Request dropped before ack: a request is only sampled in IDLE, so a dispatched call always completes. Its ack is still pulsed.
- rst asserted mid-call: every register takes its reset value immediately (asynchronous); INIT is re-entered after release.
- Sticky flags clear only on rst.

Test Plan:
- Reset release, iDone forced high for 2 cycles while oCall=0 -> flag ignored. Then oCall=0001; iDone pulse at cycle 50 -> oCall=0 and init_done=1 at cycle 51; no other call before cycle 52.
- wr_req with wr_addr=24'h012345, wr_data=16'hA5A5 -> oCall=1000, oAddr=24'h012345, oData=16'hA5A5 one cycle later. iDone -> wr_ack pulses exactly 1 cycle on the next edge.
- rd_req with rd_addr=24'hC00001; iDone with iData=16'h5A5A -> rd_data=16'h5A5A and rd_ack pulses once; rd_data holds 16'h5A5A afterwards.
- REFRESH_INTERVAL=16 with wr_req and rd_req held continuously -> a refresh is interleaved every 16 cycles ahead of user calls; the user calls alternate W,R,W,R.
- REFRESH_INTERVAL=16 with iDone withheld for 40 cycles -> ref_overrun=1 and stays 1. With DONE_TIMEOUT=30 -> timeout_err=1, oCall=0, then the call is re-issued.
- rst pulsed mid-WRITE -> all outputs return to their reset values immediately; after release oCall=0001 and no wr_ack is produced.

Source files
------------

// File: rtl/zsdram_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// zsdram_cmd_sequencer_if
//
// Groups both sides of the SDRAM command sequencer into one bundle.
//   User side (photon-counter data path):
//     wr_req/wr_addr/wr_data -> wr_ack
//     rd_req/rd_addr         -> rd_ack/rd_data
//     status: init_done, ref_overrun, timeout_err
//   Function side (SDRAM PHY command module):
//     oCall (one-hot), oAddr, oData -> iDone, iData
//
// Modports:
//   master : the sequencer itself (drives the calls and the user responses)
//   slave  : the environment (user logic plus function module)
// -----------------------------------------------------------------------------
interface zsdram_cmd_sequencer_if;
    // User side
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        init_done;
    logic        ref_overrun;
    logic        timeout_err;
    // Function side
    logic [3:0]  oCall;
    logic        iDone;
    logic [23:0] oAddr;
    logic [15:0] oData;
    logic [15:0] iData;

    modport master (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, iDone, iData,
        output wr_ack, rd_ack, rd_data, init_done, ref_overrun, timeout_err,
               oCall, oAddr, oData
    );

    modport slave (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, iDone, iData,
        input  wr_ack, rd_ack, rd_data, init_done, ref_overrun, timeout_err,
               oCall, oAddr, oData
    );
endinterface

// File: rtl/zsdram_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// zsdram_cmd_sequencer
//
// Initiator-side sequencer for the SDRAM function module. After reset it
// issues the power-up initial call, then keeps a periodic refresh schedule
// and arbitrates user write/read requests into single-word calls.
//
// Ports:
//   clk  : system clock (133 MHz)
//   rst  : asynchronous, active-high reset
//   bus  : zsdram_cmd_sequencer_if.master
//          user side     wr_req/wr_addr/wr_data/wr_ack,
//                        rd_req/rd_addr/rd_ack/rd_data,
//                        init_done, ref_overrun (sticky), timeout_err (sticky)
//          function side oCall[3:0] = {write, read, refresh, initial},
//                        oAddr, oData, iDone, iData
//
// Parameters:
//   REFRESH_INTERVAL : clk cycles between refresh requests
//   DONE_TIMEOUT     : max cycles a call may stay outstanding
// -----------------------------------------------------------------------------
module zsdram_cmd_sequencer #(
    parameter logic [15:0] REFRESH_INTERVAL = 16'd1037,
    parameter logic [15:0] DONE_TIMEOUT     = 16'd20000
) (
    input  logic                         clk,
    input  logic                         rst,
    zsdram_cmd_sequencer_if.master       bus
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_REFRESH,
        S_GAP
    } state_e;

    typedef enum logic {
        RR_WRITE,
        RR_READ
    } rr_e;

    localparam logic [3:0] CALL_NONE    = 4'b0000;
    localparam logic [3:0] CALL_INIT    = 4'b0001;
    localparam logic [3:0] CALL_REFRESH = 4'b0010;
    localparam logic [3:0] CALL_READ    = 4'b0100;
    localparam logic [3:0] CALL_WRITE   = 4'b1000;

    state_e      state_q, state_d;
    rr_e         rr_last_q, rr_last_d;
    logic [3:0]  call_q, call_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        wr_ack_q, wr_ack_d;
    logic        rd_ack_q, rd_ack_d;
    logic        init_done_q, init_done_d;
    logic        ref_overrun_q, ref_overrun_d;
    logic        timeout_err_q, timeout_err_d;
    logic        ref_pending_q, ref_pending_d;
    logic [15:0] ref_cnt_q, ref_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;

    logic        done_seen;
    logic        call_expired;
    logic        ref_wrap;
    logic        ref_dispatch;
    logic        pick_write;

    // The function module holds done high out of reset, so done only counts
    // while one of our calls is actually on the bus.
    assign done_seen    = bus.iDone && (call_q != CALL_NONE);
    assign call_expired = (call_q != CALL_NONE) && (to_cnt_q == DONE_TIMEOUT - 16'd1);
    assign ref_wrap     = init_done_q && (ref_cnt_q == REFRESH_INTERVAL - 16'd1);

    // With both requests up, serve the type that did not complete last.
    assign pick_write   = bus.wr_req && (!bus.rd_req || (rr_last_q == RR_READ));

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned; that is what keeps this combinational and latch-free.
    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        call_d        = call_q;
        addr_d        = addr_q;
        data_d        = data_q;
        rd_data_d     = rd_data_q;
        wr_ack_d      = 1'b0;
        rd_ack_d      = 1'b0;
        init_done_d   = init_done_q;
        timeout_err_d = timeout_err_q;
        ref_dispatch  = 1'b0;
        // Per-call age: zero while idle, so it starts at 0 on the first call cycle.
        to_cnt_d      = (call_q != CALL_NONE) ? to_cnt_q + 16'd1 : 16'd0;
        ref_cnt_d     = ref_cnt_q;

        if (init_done_q) begin
            ref_cnt_d = ref_wrap ? 16'd0 : ref_cnt_q + 16'd1;
        end

        case (state_q)
            S_INIT: begin
                if (call_q == CALL_NONE) begin
                    call_d = CALL_INIT;
                end else if (done_seen) begin
                    call_d      = CALL_NONE;
                    init_done_d = 1'b1;
                    state_d     = S_GAP;
                end else if (call_expired) begin
                    call_d        = CALL_NONE;
                    timeout_err_d = 1'b1;
                    state_d       = S_GAP;
                end
            end

            S_IDLE: begin
                if (ref_pending_q) begin
                    call_d       = CALL_REFRESH;
                    ref_dispatch = 1'b1;
                    state_d      = S_REFRESH;
                end else if (pick_write) begin
                    call_d  = CALL_WRITE;
                    addr_d  = bus.wr_addr;
                    data_d  = bus.wr_data;
                    state_d = S_WRITE;
                end else if (bus.rd_req) begin
                    call_d  = CALL_READ;
                    addr_d  = bus.rd_addr;
                    state_d = S_READ;
                end
            end

            S_WRITE, S_READ, S_REFRESH: begin
                if (done_seen) begin
                    call_d  = CALL_NONE;
                    state_d = S_GAP;
                    if (state_q == S_WRITE) begin
                        wr_ack_d  = 1'b1;
                        rr_last_d = RR_WRITE;
                    end else if (state_q == S_READ) begin
                        rd_data_d = bus.iData;
                        rd_ack_d  = 1'b1;
                        rr_last_d = RR_READ;
                    end
                end else if (call_expired) begin
                    // No ack: the user request is still up and gets retried.
                    call_d        = CALL_NONE;
                    timeout_err_d = 1'b1;
                    state_d       = S_GAP;
                end
            end

            S_GAP: begin
                // One quiet cycle lets the function module return to step 0;
                // a timed-out initial call is re-issued from INIT.
                state_d = init_done_q ? S_IDLE : S_INIT;
            end

            default: begin
                state_d = S_INIT;
                call_d  = CALL_NONE;
            end
        endcase

        // A wrap in the same cycle as the refresh dispatch re-arms the request
        // instead of counting as an overrun.
        ref_pending_d = ref_pending_q;
        ref_overrun_d = ref_overrun_q;
        if (ref_dispatch) begin
            ref_pending_d = ref_wrap;
        end else if (ref_wrap) begin
            if (ref_pending_q) begin
                ref_overrun_d = 1'b1;
            end
            ref_pending_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_INIT;
            rr_last_q     <= RR_READ;
            call_q        <= CALL_NONE;
            addr_q        <= '0;
            data_q        <= '0;
            rd_data_q     <= '0;
            wr_ack_q      <= 1'b0;
            rd_ack_q      <= 1'b0;
            init_done_q   <= 1'b0;
            ref_overrun_q <= 1'b0;
            timeout_err_q <= 1'b0;
            ref_pending_q <= 1'b0;
            ref_cnt_q     <= '0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            call_q        <= call_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            rd_data_q     <= rd_data_d;
            wr_ack_q      <= wr_ack_d;
            rd_ack_q      <= rd_ack_d;
            init_done_q   <= init_done_d;
            ref_overrun_q <= ref_overrun_d;
            timeout_err_q <= timeout_err_d;
            ref_pending_q <= ref_pending_d;
            ref_cnt_q     <= ref_cnt_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign bus.oCall       = call_q;
    assign bus.oAddr       = addr_q;
    assign bus.oData       = data_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.rd_ack      = rd_ack_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.init_done   = init_done_q;
    assign bus.ref_overrun = ref_overrun_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
